// File: rtl/ec_pkg.sv
// Shared types for the EC scalar-multiply controller: FSM states,
// default operand widths and the affine point record.
package ec_pkg;

  localparam int K_W_DEF = 6;
  localparam int D_W_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DBL_CHK  = 3'd1,
    ST_DBL_WAIT = 3'd2,
    ST_ADD_CHK  = 3'd3,
    ST_ADD_WAIT = 3'd4,
    ST_NEXT     = 3'd5,
    ST_OUT      = 3'd6
  } ec_state_t;

  typedef struct packed {
    logic [D_W_DEF-1:0] x;
    logic [D_W_DEF-1:0] y;
    logic               inf;
  } ec_point_t;

endpackage

// File: rtl/ec_scalar_mul_ctrl.sv
// Left-to-right double-and-add sequencer for R = k*P. Drives an external
// point add/double engine and resolves infinity / inverse cases itself.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for in_valid; job registers load here
// DBL_CHK  | skip double if R is infinity or Ry==0, else launch double
// DBL_WAIT | waiting for engine result of R+R
// ADD_CHK  | decide add for bit k[idx]: skip, load P, cancel to inf, or launch
// ADD_WAIT | waiting for engine result of R+P
// NEXT     | step idx down, or finish after bit 0
// OUT      | one-cycle result strobe
module ec_scalar_mul_ctrl
  import ec_pkg::*;
#(
  parameter int K_W = K_W_DEF,
  parameter int D_W = D_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [K_W-1:0] in_k,
  input  logic [D_W-1:0] in_Px,
  input  logic [D_W-1:0] in_Py,
  input  logic [D_W-1:0] in_prime,
  input  logic [D_W-1:0] in_a,
  output logic           eng_start,
  output logic [D_W-1:0] eng_Px,
  output logic [D_W-1:0] eng_Py,
  output logic [D_W-1:0] eng_Qx,
  output logic [D_W-1:0] eng_Qy,
  output logic [D_W-1:0] eng_prime,
  output logic [D_W-1:0] eng_a,
  input  logic           eng_done,
  input  logic [D_W-1:0] eng_Rx,
  input  logic [D_W-1:0] eng_Ry,
  output logic           busy,
  output logic           out_valid,
  output logic [D_W-1:0] out_Rx,
  output logic [D_W-1:0] out_Ry,
  output logic           out_inf
);

  localparam int IW = (K_W > 1) ? $clog2(K_W) : 1;

  ec_state_t      state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic [D_W-1:0] px_q, px_d, py_q, py_d;
  logic [D_W-1:0] prime_q, prime_d, a_q, a_d;
  logic [D_W-1:0] rx_q, rx_d, ry_q, ry_d;
  logic           rinf_q, rinf_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           out_valid_q, out_valid_d;
  logic [D_W-1:0] out_rx_q, out_rx_d, out_ry_q, out_ry_d;
  logic           out_inf_q, out_inf_d;

  logic           dbl_skip;
  logic           add_is_inverse;

  assign dbl_skip       = rinf_q || (ry_q == '0);
  assign add_is_inverse = (rx_q == px_q) && (ry_q != py_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      px_q        <= '0;
      py_q        <= '0;
      prime_q     <= '0;
      a_q         <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      rinf_q      <= 1'b1;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_rx_q    <= '0;
      out_ry_q    <= '0;
      out_inf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      px_q        <= px_d;
      py_q        <= py_d;
      prime_q     <= prime_d;
      a_q         <= a_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      rinf_q      <= rinf_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_rx_q    <= out_rx_d;
      out_ry_q    <= out_ry_d;
      out_inf_q   <= out_inf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    px_d        = px_q;
    py_d        = py_q;
    prime_d     = prime_q;
    a_d         = a_q;
    rx_d        = rx_q;
    ry_d        = ry_q;
    rinf_d      = rinf_q;
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    out_rx_d    = '0;
    out_ry_d    = '0;
    out_inf_d   = 1'b0;
    eng_start   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          k_d     = in_k;
          px_d    = in_Px;
          py_d    = in_Py;
          prime_d = in_prime;
          a_d     = in_a;
          rinf_d  = 1'b1;
          idx_d   = IW'(K_W - 1);
          state_d = ST_DBL_CHK;
        end
      end
      ST_DBL_CHK: begin
        // A point with y==0 doubles to infinity; the engine cannot express that.
        if (dbl_skip) begin
          rinf_d  = 1'b1;
          state_d = ST_ADD_CHK;
        end else begin
          eng_start = 1'b1;
          state_d   = ST_DBL_WAIT;
        end
      end
      ST_DBL_WAIT: begin
        if (eng_done) begin
          rx_d    = eng_Rx;
          ry_d    = eng_Ry;
          state_d = ST_ADD_CHK;
        end
      end
      ST_ADD_CHK: begin
        if (!k_q[idx_q]) begin
          state_d = ST_NEXT;
        end else if (rinf_q) begin
          rx_d    = px_q;
          ry_d    = py_q;
          rinf_d  = 1'b0;
          state_d = ST_NEXT;
        end else if (add_is_inverse) begin
          rinf_d  = 1'b1;
          state_d = ST_NEXT;
        end else begin
          // R==P also goes to the engine, which doubles equal operands.
          eng_start = 1'b1;
          state_d   = ST_ADD_WAIT;
        end
      end
      ST_ADD_WAIT: begin
        if (eng_done) begin
          rx_d    = eng_Rx;
          ry_d    = eng_Ry;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx_q == '0) begin
          out_valid_d = 1'b1;
          out_inf_d   = rinf_q;
          out_rx_d    = rinf_q ? '0 : rx_q;
          out_ry_d    = rinf_q ? '0 : ry_q;
          state_d     = ST_OUT;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = ST_DBL_CHK;
        end
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operands are forced to zero outside the launch cycle.
  assign eng_Px    = eng_start ? rx_q : '0;
  assign eng_Py    = eng_start ? ry_q : '0;
  assign eng_Qx    = !eng_start ? '0 : (state_q == ST_DBL_CHK) ? rx_q : px_q;
  assign eng_Qy    = !eng_start ? '0 : (state_q == ST_DBL_CHK) ? ry_q : py_q;
  assign eng_prime = prime_q;
  assign eng_a     = a_q;

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_Rx    = out_rx_q;
  assign out_Ry    = out_ry_q;
  assign out_inf   = out_inf_q;

endmodule

// File: tb/tb_ec_scalar_mul_ctrl.sv
// Directed bench for ec_scalar_mul_ctrl on y^2 = x^3 + 2x + 2 mod 17, P=(5,1),
// with a behavioural fixed-latency point add/double engine.
module tb_ec_scalar_mul_ctrl;

  localparam int K_W = 6;
  localparam int D_W = 6;
  localparam int L   = 3;
  localparam int NV  = 11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [K_W-1:0] in_k = '0;
  logic [D_W-1:0] in_Px = '0, in_Py = '0, in_prime = '0, in_a = '0;
  logic           eng_start;
  logic [D_W-1:0] eng_Px, eng_Py, eng_Qx, eng_Qy, eng_prime, eng_a;
  logic           eng_done = 1'b0;
  logic [D_W-1:0] eng_Rx = '0, eng_Ry = '0;
  logic           busy, out_valid, out_inf;
  logic [D_W-1:0] out_Rx, out_Ry;

  ec_scalar_mul_ctrl #(.K_W(K_W), .D_W(D_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_k(in_k),
    .in_Px(in_Px), .in_Py(in_Py), .in_prime(in_prime), .in_a(in_a),
    .eng_start(eng_start), .eng_Px(eng_Px), .eng_Py(eng_Py),
    .eng_Qx(eng_Qx), .eng_Qy(eng_Qy), .eng_prime(eng_prime), .eng_a(eng_a),
    .eng_done(eng_done), .eng_Rx(eng_Rx), .eng_Ry(eng_Ry),
    .busy(busy), .out_valid(out_valid), .out_Rx(out_Rx), .out_Ry(out_Ry),
    .out_inf(out_inf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int start_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eng_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  // Behavioural engine: affine add, or double when operands are equal.
  function automatic int md(int v, int p);
    int r;
    r = v % p;
    if (r < 0) r = r + p;
    return r;
  endfunction

  function automatic int inv(int v, int p);
    for (int i = 1; i < p; i++) if (md(v * i, p) == 1) return i;
    return 0;
  endfunction

  function automatic logic [11:0] ec_op(int x1, int y1, int x2, int y2, int p, int a);
    int num, den, lam, x3, y3;
    if (x1 == x2 && y1 == y2) begin
      num = md(3 * x1 * x1 + a, p);
      den = md(2 * y1, p);
    end else begin
      num = md(y2 - y1, p);
      den = md(x2 - x1, p);
    end
    lam = md(num * inv(den, p), p);
    x3  = md(lam * lam - x1 - x2, p);
    y3  = md(lam * (x1 - x3) - y1, p);
    return {x3[5:0], y3[5:0]};
  endfunction

  int          eng_cnt = 0;
  logic [11:0] eng_res = '0;
  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (eng_start === 1'b1) begin
      eng_res <= ec_op(int'(eng_Px), int'(eng_Py), int'(eng_Qx), int'(eng_Qy),
                       int'(eng_prime), int'(eng_a));
      eng_cnt <= L - 1;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_done <= 1'b1;
        eng_Rx   <= eng_res[11:6];
        eng_Ry   <= eng_res[5:0];
      end
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [K_W-1:0] k;
    logic           inf;
    int             x;
    int             y;
    int             starts;
  } vec_t;

  vec_t vecs [NV];

  int          got_lat, got_starts, got_x, got_y, got_inf, got_ok;

  // Launch one job at a negedge and wait (bounded) for its out_valid.
  task automatic run_job(input logic [K_W-1:0] k);
    int t0, s0, n;
    @(negedge clk);
    in_k = k; in_Px = 6'd5; in_Py = 6'd1; in_prime = 6'd17; in_a = 6'd2;
    in_valid = 1'b1;
    t0 = cyc; s0 = start_cnt;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    got_ok     = (out_valid === 1'b1) ? 1 : 0;
    got_lat    = cyc - t0;
    got_x      = int'(out_Rx);
    got_y      = int'(out_Ry);
    got_inf    = int'(out_inf);
    got_starts = start_cnt - s0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_lat, n, ov_seen, bad_samples;

    vecs[0]  = '{k: 6'd0,  inf: 1'b1, x: 0,  y: 0,  starts: 0};
    vecs[1]  = '{k: 6'd1,  inf: 1'b0, x: 5,  y: 1,  starts: 0};
    vecs[2]  = '{k: 6'd2,  inf: 1'b0, x: 6,  y: 3,  starts: 1};
    vecs[3]  = '{k: 6'd3,  inf: 1'b0, x: 10, y: 6,  starts: 2};
    vecs[4]  = '{k: 6'd7,  inf: 1'b0, x: 0,  y: 6,  starts: 4};
    vecs[5]  = '{k: 6'd18, inf: 1'b0, x: 5,  y: 16, starts: 5};
    vecs[6]  = '{k: 6'd19, inf: 1'b1, x: 0,  y: 0,  starts: 5};
    vecs[7]  = '{k: 6'd21, inf: 1'b0, x: 6,  y: 3,  starts: 6};
    vecs[8]  = '{k: 6'd38, inf: 1'b1, x: 0,  y: 0,  starts: 5};
    vecs[9]  = '{k: 6'd63, inf: 1'b0, x: 16, y: 13, starts: 10};
    vecs[10] = '{k: 6'd5,  inf: 1'b0, x: 9,  y: 16, starts: 3};

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_xyinf", int'({out_Rx, out_Ry, out_inf}), 0);
    check("rst_eng", int'({eng_start, eng_prime, eng_a, eng_Px, eng_Qx}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_job(vecs[i].k);
      exp_lat = 3 * K_W + 1 + L * vecs[i].starts;
      check($sformatf("k%0d_done", vecs[i].k), got_ok, 1);
      check($sformatf("k%0d_inf", vecs[i].k), got_inf, int'(vecs[i].inf));
      check($sformatf("k%0d_x", vecs[i].k), got_x, vecs[i].x);
      check($sformatf("k%0d_y", vecs[i].k), got_y, vecs[i].y);
      check($sformatf("k%0d_starts", vecs[i].k), got_starts, vecs[i].starts);
      check($sformatf("k%0d_latency", vecs[i].k), got_lat, exp_lat);
      check($sformatf("k%0d_eng_prime", vecs[i].k), int'(eng_prime), 17);
      @(negedge clk);
      check($sformatf("k%0d_pulse_end", vecs[i].k),
            int'({out_valid, busy, out_Rx, out_Ry, out_inf}), 0);
    end

    // in_valid while busy must be dropped: the job keeps k=5.
    @(negedge clk);
    in_k = 6'd5; in_Px = 6'd5; in_Py = 6'd1; in_prime = 6'd17; in_a = 6'd2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    in_k = 6'd2; in_Px = 6'd6; in_Py = 6'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ov_seen = 0; n = 0;
    got_x = -1; got_y = -1; got_inf = -1;
    while (n < 120) begin
      if (out_valid === 1'b1) begin
        ov_seen++;
        got_x = int'(out_Rx); got_y = int'(out_Ry); got_inf = int'(out_inf);
      end
      @(negedge clk);
      n++;
    end
    check("busy_ign_ov_count", ov_seen, 1);
    check("busy_ign_x", got_x, 9);
    check("busy_ign_y", got_y, 16);
    check("busy_ign_inf", got_inf, 0);

    // Reset during DBL_WAIT; the engine's late eng_done must be ignored.
    @(negedge clk);
    in_k = 6'd2; in_Px = 6'd5; in_Py = 6'd1; in_prime = 6'd17; in_a = 6'd2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (eng_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_saw_start", int'(eng_start), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_outs", int'({out_valid, out_Rx, out_Ry, out_inf, eng_prime}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad_samples = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || out_valid !== 1'b0 || eng_start !== 1'b0 ||
          out_Rx !== '0 || out_Ry !== '0 || out_inf !== 1'b0)
        bad_samples++;
    end
    check("rstmid_quiet", bad_samples, 0);

    run_job(6'd3);
    check("after_rst_done", got_ok, 1);
    check("after_rst_x", got_x, 10);
    check("after_rst_y", got_y, 6);
    check("after_rst_inf", got_inf, 0);
    check("after_rst_starts", got_starts, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
